// File: rtl/clock_manager.sv
// Clock/reset manager: synchronises PLL lock, sequences the system reset release
// and produces per-channel clock-enable strobes from phase-accumulator dividers.
module clock_manager #(
    parameter int CHANNELS    = 2,
    parameter int ACC_WIDTH   = 16,
    parameter int LOCK_STABLE = 1024,
    parameter int RESET_HOLD  = 16
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          pll_locked,
    input  logic [CHANNELS*ACC_WIDTH-1:0] increment,
    input  logic                          lock_lost_clear,
    output logic [CHANNELS-1:0]           enable_out,
    output logic                          sys_reset_n,
    output logic                          lock_lost
);

    localparam int MAX_COUNT = (LOCK_STABLE > RESET_HOLD) ? LOCK_STABLE : RESET_HOLD;
    localparam int CNT_WIDTH = ($clog2(MAX_COUNT) < 1) ? 1 : $clog2(MAX_COUNT);
    localparam logic [CNT_WIDTH-1:0] STABLE_LAST = CNT_WIDTH'(LOCK_STABLE - 1);
    localparam logic [CNT_WIDTH-1:0] HOLD_LAST   = CNT_WIDTH'(RESET_HOLD - 1);

    generate
        if (CHANNELS < 1) begin : g_bad_channels
            $error("clock_manager: CHANNELS must be at least 1");
        end
        if (ACC_WIDTH < 2 || ACC_WIDTH > 32) begin : g_bad_acc_width
            $error("clock_manager: ACC_WIDTH must be in 2..32");
        end
        if (LOCK_STABLE < 1) begin : g_bad_lock_stable
            $error("clock_manager: LOCK_STABLE must be at least 1");
        end
        if (RESET_HOLD < 1) begin : g_bad_reset_hold
            $error("clock_manager: RESET_HOLD must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILISE = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t                             state;
    state_t                             state_next;
    logic [CNT_WIDTH-1:0]               counter;
    logic [CNT_WIDTH-1:0]               counter_next;
    logic                               sync_meta;
    logic                               locked_s;
    logic [CHANNELS-1:0][ACC_WIDTH-1:0] acc;
    logic [CHANNELS-1:0][ACC_WIDTH-1:0] acc_next;
    logic [CHANNELS-1:0]                enable_next;
    logic [ACC_WIDTH:0]                 sum_wide [CHANNELS];
    logic                               sys_reset_next;
    logic                               lock_lost_next;

    // pll_locked is asynchronous to clock, so it only enters the design through two flops.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= 1'b0;
            locked_s  <= 1'b0;
        end else begin
            sync_meta <= pll_locked;
            locked_s  <= sync_meta;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= WAIT_LOCK;
            counter <= '0;
        end else begin
            state   <= state_next;
            counter <= counter_next;
        end
    end

    always_comb begin
        state_next   = state;
        counter_next = counter;
        case (state)
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_next   = STABILISE;
                    counter_next = '0;
                end
            end
            STABILISE: begin
                if (!locked_s) begin
                    state_next   = WAIT_LOCK;
                    counter_next = '0;
                end else if (counter == STABLE_LAST) begin
                    state_next   = HOLD;
                    counter_next = '0;
                end else begin
                    counter_next = counter + CNT_WIDTH'(1);
                end
            end
            HOLD: begin
                if (!locked_s) begin
                    state_next   = WAIT_LOCK;
                    counter_next = '0;
                end else if (counter == HOLD_LAST) begin
                    state_next   = RUN;
                    counter_next = '0;
                end else begin
                    counter_next = counter + CNT_WIDTH'(1);
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_next   = WAIT_LOCK;
                    counter_next = '0;
                end
            end
            default: begin
                state_next   = WAIT_LOCK;
                counter_next = '0;
            end
        endcase
    end

    // The extra top bit of each sum is the carry that becomes that channel's strobe.
    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_sum
            assign sum_wide[gi] = {1'b0, acc[gi]} + {1'b0, increment[gi*ACC_WIDTH +: ACC_WIDTH]};
        end
    endgenerate

    // Outputs follow the next state so enables start on HOLD entry and stop on the edge leaving RUN.
    always_comb begin
        acc_next       = '0;
        enable_next    = '0;
        sys_reset_next = (state_next == RUN);
        lock_lost_next = lock_lost;
        if (state_next == HOLD || state_next == RUN) begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc_next[i]    = sum_wide[i][ACC_WIDTH-1:0];
                enable_next[i] = sum_wide[i][ACC_WIDTH];
            end
        end
        if (lock_lost_clear) begin
            lock_lost_next = 1'b0;
        end
        if (state == RUN && state_next == WAIT_LOCK) begin
            lock_lost_next = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc         <= '0;
            enable_out  <= '0;
            sys_reset_n <= 1'b0;
            lock_lost   <= 1'b0;
        end else begin
            acc         <= acc_next;
            enable_out  <= enable_next;
            sys_reset_n <= sys_reset_next;
            lock_lost   <= lock_lost_next;
        end
    end

endmodule

// File: tb/tb_clock_manager.sv
// Directed bench for clock_manager: a vector table for bring-up and run-time loss,
// plus hand-written sequences for unstable lock, sticky fault, async reset and dividers.
module tb_clock_manager;

    localparam int CHANNELS    = 2;
    localparam int ACC_WIDTH   = 16;
    localparam int LOCK_STABLE = 8;
    localparam int RESET_HOLD  = 4;
    localparam int BRING_UP    = 2 + LOCK_STABLE + RESET_HOLD;
    localparam int NUM_VECS    = 20;

    logic                          clock;
    logic                          reset_n;
    logic                          pll_locked;
    logic [CHANNELS*ACC_WIDTH-1:0] increment;
    logic                          lock_lost_clear;
    logic [CHANNELS-1:0]           enable_out;
    logic                          sys_reset_n;
    logic                          lock_lost;

    int total_checks  = 0;
    int passed_checks = 0;

    typedef struct {
        logic        pll;
        logic [15:0] inc0;
        logic [15:0] inc1;
        logic        clr;
        logic [1:0]  exp_en;
        logic        exp_srst;
        logic        exp_ll;
    } vector_t;

    vector_t vecs [NUM_VECS];

    int   nonzero_count;
    int   pulses;
    int   wide_pulses;
    int   alt_bad;
    int   srst_bad;
    int   en_bad;
    int   ll_bad;
    logic prev0;
    logic prev1;
    logic [1:0] exp_en;

    clock_manager #(
        .CHANNELS   (CHANNELS),
        .ACC_WIDTH  (ACC_WIDTH),
        .LOCK_STABLE(LOCK_STABLE),
        .RESET_HOLD (RESET_HOLD)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .pll_locked     (pll_locked),
        .increment      (increment),
        .lock_lost_clear(lock_lost_clear),
        .enable_out     (enable_out),
        .sys_reset_n    (sys_reset_n),
        .lock_lost      (lock_lost)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_checks++;
        if (actual === expected) begin
            passed_checks++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic pll, input logic [15:0] inc0, input logic [15:0] inc1, input logic clr);
        pll_locked      = pll;
        increment       = {inc1, inc0};
        lock_lost_clear = clr;
    endtask

    task automatic stepClock();
        @(posedge clock);
        #1;
    endtask

    task automatic doReset(input string tag);
        reset_n         = 1'b0;
        pll_locked      = 1'b0;
        lock_lost_clear = 1'b0;
        stepClock();
        stepClock();
        checkOutput({tag, " reset sys_reset_n"}, 32'(sys_reset_n), 32'd0);
        checkOutput({tag, " reset enable_out"}, 32'(enable_out), 32'd0);
        checkOutput({tag, " reset lock_lost"}, 32'(lock_lost), 32'd0);
        reset_n = 1'b1;
        stepClock();
        stepClock();
    endtask

    // Raises pll_locked just before edge 0 and walks to edge BRING_UP.
    task automatic bringUp(input string tag);
        pll_locked = 1'b1;
        for (int e = 0; e < BRING_UP; e++) begin
            stepClock();
        end
        checkOutput({tag, " sys_reset_n held"}, 32'(sys_reset_n), 32'd0);
        stepClock();
        checkOutput({tag, " sys_reset_n released"}, 32'(sys_reset_n), 32'd1);
    endtask

    initial begin
        reset_n         = 1'b0;
        pll_locked      = 1'b0;
        increment       = '0;
        lock_lost_clear = 1'b0;

        // Bring-up with ch0 at half rate and ch1 at full-scale increment, then loss and clear.
        for (int i = 0; i < 10; i++) begin
            vecs[i] = '{1'b1, 16'd32768, 16'd65535, 1'b0, 2'b00, 1'b0, 1'b0};
        end
        vecs[10] = '{1'b1, 16'd32768, 16'd65535, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 16'd32768, 16'd65535, 1'b0, 2'b11, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 16'd32768, 16'd65535, 1'b0, 2'b10, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 16'd32768, 16'd65535, 1'b0, 2'b11, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 16'd32768, 16'd65535, 1'b0, 2'b10, 1'b1, 1'b0};
        vecs[15] = '{1'b1, 16'd32768, 16'd65535, 1'b0, 2'b11, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 16'd32768, 16'd65535, 1'b0, 2'b10, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 16'd32768, 16'd65535, 1'b0, 2'b11, 1'b1, 1'b0};
        vecs[18] = '{1'b0, 16'd32768, 16'd65535, 1'b0, 2'b00, 1'b0, 1'b1};
        vecs[19] = '{1'b0, 16'd32768, 16'd65535, 1'b1, 2'b00, 1'b0, 1'b0};

        doReset("initial");
        checkOutput("idle sys_reset_n", 32'(sys_reset_n), 32'd0);

        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(vecs[i].pll, vecs[i].inc0, vecs[i].inc1, vecs[i].clr);
            stepClock();
            checkOutput($sformatf("vec%0d enable_out", i), 32'(enable_out), 32'(vecs[i].exp_en));
            checkOutput($sformatf("vec%0d sys_reset_n", i), 32'(sys_reset_n), 32'(vecs[i].exp_srst));
            checkOutput($sformatf("vec%0d lock_lost", i), 32'(lock_lost), 32'(vecs[i].exp_ll));
        end
        lock_lost_clear = 1'b0;

        // Unstable lock: 3-cycle drop mid-STABILISE; relock at edge 10 puts RUN at edge 24.
        doReset("unstable");
        applyStimulus(1'b1, 16'd65535, 16'd0, 1'b0);
        srst_bad = 0;
        en_bad   = 0;
        ll_bad   = 0;
        for (int e = 0; e <= 24; e++) begin
            pll_locked = (e >= 7 && e <= 9) ? 1'b0 : 1'b1;
            stepClock();
            exp_en = (e >= 21) ? 2'b01 : 2'b00;
            if (sys_reset_n !== ((e >= 24) ? 1'b1 : 1'b0)) srst_bad++;
            if (enable_out !== exp_en) en_bad++;
            if (lock_lost !== 1'b0) ll_bad++;
        end
        checkOutput("unstable sys_reset_n sequence errors", 32'(srst_bad), 32'd0);
        checkOutput("unstable enable_out sequence errors", 32'(en_bad), 32'd0);
        checkOutput("unstable lock_lost errors", 32'(ll_bad), 32'd0);

        // Run-time loss, sticky fault through relock, explicit clear, and clear colliding with loss.
        doReset("sticky");
        applyStimulus(1'b1, 16'd65535, 16'd0, 1'b0);
        bringUp("sticky bring-up");
        pll_locked = 1'b0;
        stepClock();
        stepClock();
        checkOutput("loss edge1 sys_reset_n", 32'(sys_reset_n), 32'd1);
        stepClock();
        checkOutput("loss edge2 sys_reset_n", 32'(sys_reset_n), 32'd0);
        checkOutput("loss edge2 enable_out", 32'(enable_out), 32'd0);
        checkOutput("loss edge2 lock_lost", 32'(lock_lost), 32'd1);
        bringUp("relock");
        checkOutput("lock_lost held after relock", 32'(lock_lost), 32'd1);
        lock_lost_clear = 1'b1;
        stepClock();
        lock_lost_clear = 1'b0;
        checkOutput("lock_lost cleared", 32'(lock_lost), 32'd0);
        pll_locked = 1'b0;
        stepClock();
        stepClock();
        lock_lost_clear = 1'b1;
        stepClock();
        lock_lost_clear = 1'b0;
        checkOutput("set beats clear lock_lost", 32'(lock_lost), 32'd1);

        // Async reset while running with lock_lost set, then bring-up again with lock held.
        bringUp("pre-async");
        checkOutput("pre-async enable_out", 32'(enable_out), 32'd1);
        #3;
        reset_n = 1'b0;
        #1;
        checkOutput("async sys_reset_n", 32'(sys_reset_n), 32'd0);
        checkOutput("async enable_out", 32'(enable_out), 32'd0);
        checkOutput("async lock_lost", 32'(lock_lost), 32'd0);
        stepClock();
        reset_n = 1'b1;
        bringUp("post-async");
        checkOutput("post-async lock_lost", 32'(lock_lost), 32'd0);

        // Zero increment never strobes; a change in RUN applies from the next add.
        doReset("increment");
        applyStimulus(1'b1, 16'd0, 16'd0, 1'b0);
        bringUp("increment bring-up");
        nonzero_count = 0;
        for (int c = 0; c < 20; c++) begin
            stepClock();
            if (enable_out !== 2'b00) nonzero_count++;
        end
        checkOutput("zero increment strobes", 32'(nonzero_count), 32'd0);
        increment[15:0] = 16'd65535;
        stepClock();
        checkOutput("inc change first add", 32'(enable_out), 32'd0);
        stepClock();
        checkOutput("inc change second add", 32'(enable_out), 32'd1);
        increment[15:0] = 16'd0;
        stepClock();
        checkOutput("inc back to zero", 32'(enable_out), 32'd0);

        // Divider accuracy over one full accumulator period.
        increment = {16'd32768, 16'd3584};
        stepClock();
        stepClock();
        prev0       = enable_out[0];
        prev1       = enable_out[1];
        pulses      = 0;
        wide_pulses = 0;
        alt_bad     = 0;
        for (int c = 0; c < 65536; c++) begin
            stepClock();
            if (enable_out[0]) pulses++;
            if (enable_out[0] && prev0) wide_pulses++;
            if (enable_out[1] === prev1) alt_bad++;
            prev0 = enable_out[0];
            prev1 = enable_out[1];
        end
        checkOutput("ch0 pulses per 65536", 32'(pulses), 32'd3584);
        checkOutput("ch0 wide pulses", 32'(wide_pulses), 32'd0);
        checkOutput("ch1 alternation errors", 32'(alt_bad), 32'd0);
        checkOutput("divider run sys_reset_n", 32'(sys_reset_n), 32'd1);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
